// File: rtl/ts_tag_arbiter.sv
// ts_tag_arbiter: gathers timestamp tags from several timestamper channels
// into one channel-tagged stream. Each channel has a one-deep holding
// register; a round-robin arbiter moves held tags into a first-word-fall-through
// FIFO drained by a valid/ready consumer. Tags arriving on an occupied
// holding register are dropped and counted.
module ts_tag_arbiter #(
  parameter int g_num_channels = 4,
  parameter int g_fifo_depth   = 16
) (
  input  logic                               clk_ref_i,
  input  logic                               rst_n_i,
  input  logic [g_num_channels-1:0]          enable_i,
  input  logic [23*g_num_channels-1:0]       tag_frac_i,
  input  logic [28*g_num_channels-1:0]       tag_coarse_i,
  input  logic [32*g_num_channels-1:0]       tag_utc_i,
  input  logic [g_num_channels-1:0]          tag_valid_p1_i,
  output logic [22:0]                        out_frac_o,
  output logic [27:0]                        out_coarse_o,
  output logic [31:0]                        out_utc_o,
  output logic [2:0]                         out_channel_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [$clog2(g_fifo_depth):0]      fifo_count_o,
  output logic [g_num_channels-1:0]          overflow_o,
  output logic [15:0]                        drop_count_o,
  input  logic                               clear_i
);

  localparam int unsigned N  = g_num_channels;
  localparam int unsigned AW = $clog2(g_fifo_depth);
  localparam int unsigned EW = 3 + 32 + 28 + 23;
  localparam logic [AW:0] DEPTH = (AW+1)'(g_fifo_depth);

  typedef logic [EW-1:0] entry_t;

  // Per-channel holding registers
  logic [N-1:0] pending;
  logic [22:0]  hold_frac   [N];
  logic [27:0]  hold_coarse [N];
  logic [31:0]  hold_utc    [N];

  // Arbitration
  logic [2:0]   ptr;
  logic [2:0]   next_ptr;
  logic         grant;
  logic [N-1:0] grant_oh;
  entry_t       grant_entry;

  // Capture / drop decode
  logic [N-1:0] strobe;
  logic [N-1:0] load;
  logic [N-1:0] drop;
  logic [3:0]   n_drop;
  logic [16:0]  drop_sum;

  // Output FIFO
  entry_t       mem [g_fifo_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic         full;
  logic         pop;
  entry_t       head;

  assign full = (count == DEPTH);
  assign pop  = (count != '0) && out_ready_i;
  assign head = mem[rd_ptr];

  // Round-robin search upward from ptr with wrap; first pending channel wins.
  // The inner loop matches the rotated position against each channel index so
  // no variable-width index or modulo is needed.
  always_comb begin
    grant       = 1'b0;
    grant_oh    = '0;
    grant_entry = '0;
    next_ptr    = ptr;
    if (!full) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned c = 0; c < N; c++) begin
          if (!grant && pending[c] &&
              ((32'(ptr) + i == c) || (32'(ptr) + i == c + N))) begin
            grant       = 1'b1;
            grant_oh[c] = 1'b1;
            grant_entry = {3'(c), hold_utc[c], hold_coarse[c], hold_frac[c]};
            next_ptr    = (c == N - 1) ? 3'd0 : 3'(c + 1);
          end
        end
      end
    end
  end

  // Decide per channel whether a strobe loads the holding register or drops.
  always_comb begin
    strobe = '0;
    load   = '0;
    drop   = '0;
    n_drop = '0;
    for (int unsigned c = 0; c < N; c++) begin
      strobe[c] = tag_valid_p1_i[c] & enable_i[c];
      load[c]   = strobe[c] & (~pending[c] | grant_oh[c]);
      drop[c]   = strobe[c] & pending[c] & ~grant_oh[c];
      n_drop    = n_drop + 4'(drop[c]);
    end
    drop_sum = {1'b0, drop_count_o} + 17'(n_drop);
  end

  // Holding registers: load on accepted strobe, release on grant.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= '0;
      for (int unsigned c = 0; c < N; c++) begin
        hold_frac[c]   <= '0;
        hold_coarse[c] <= '0;
        hold_utc[c]    <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N; c++) begin
        if (load[c]) begin
          pending[c]     <= 1'b1;
          hold_frac[c]   <= tag_frac_i[23*c +: 23];
          hold_coarse[c] <= tag_coarse_i[28*c +: 28];
          hold_utc[c]    <= tag_utc_i[32*c +: 32];
        end else if (grant_oh[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the granted channel only.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= next_ptr;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_ref_i) begin
    if (grant) mem[wr_ptr] <= grant_entry;
  end

  // Sticky drop flags and saturating drop counter; clear wins over a drop.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o   <= '0;
      drop_count_o <= '0;
    end else if (clear_i) begin
      overflow_o   <= '0;
      drop_count_o <= '0;
    end else begin
      overflow_o   <= overflow_o | drop;
      drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Head fields are forced to zero while empty so reset leaves all outputs 0.
  always_comb begin
    out_valid_o  = (count != '0);
    fifo_count_o = count;
    {out_channel_o, out_utc_o, out_coarse_o, out_frac_o} = out_valid_o ? head : '0;
  end

endmodule

// File: tb/tb_ts_tag_arbiter.sv
// Directed bench for ts_tag_arbiter: a per-cycle vector table for basic
// flow and round-robin order, plus hand sequences for full FIFO, drops,
// clear priority, enable gating and asynchronous reset.
module tb_ts_tag_arbiter;

  localparam int NC = 4;
  localparam int FD = 16;

  logic          clk_ref_i = 1'b0;
  logic          rst_n_i;
  logic [NC-1:0] enable_i;
  logic [23*NC-1:0] tag_frac_i;
  logic [28*NC-1:0] tag_coarse_i;
  logic [32*NC-1:0] tag_utc_i;
  logic [NC-1:0] tag_valid_p1_i;
  logic [22:0]   out_frac_o;
  logic [27:0]   out_coarse_o;
  logic [31:0]   out_utc_o;
  logic [2:0]    out_channel_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [4:0]    fifo_count_o;
  logic [NC-1:0] overflow_o;
  logic [15:0]   drop_count_o;
  logic          clear_i;

  int errors = 0;
  int checks = 0;

  ts_tag_arbiter #(.g_num_channels(NC), .g_fifo_depth(FD)) dut (
    .clk_ref_i     (clk_ref_i),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .tag_frac_i    (tag_frac_i),
    .tag_coarse_i  (tag_coarse_i),
    .tag_utc_i     (tag_utc_i),
    .tag_valid_p1_i(tag_valid_p1_i),
    .out_frac_o    (out_frac_o),
    .out_coarse_o  (out_coarse_o),
    .out_utc_o     (out_utc_o),
    .out_channel_o (out_channel_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .fifo_count_o  (fifo_count_o),
    .overflow_o    (overflow_o),
    .drop_count_o  (drop_count_o),
    .clear_i       (clear_i)
  );

  always #5 clk_ref_i = ~clk_ref_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic [3:0] en;
    logic [3:0] vld;
    logic       rdy;
    logic       ev;
    int         ech;
    int         erow;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic [3:0] en, logic [3:0] vld, logic rdy,
                     logic ev, int ech, int erow, int ecnt);
    vec_t v;
    v.en = en; v.vld = vld; v.rdy = rdy;
    v.ev = ev; v.ech = ech; v.erow = erow; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_tag(int c, int id);
    tag_frac_i[23*c +: 23]   = 23'(id);
    tag_coarse_i[28*c +: 28] = 28'(id + 1000);
    tag_utc_i[32*c +: 32]    = 32'(id * 3 + 5);
  endtask

  task automatic chk_head(string nm, int ch, int id);
    chk({nm, "_chan"},   32'(out_channel_o), 32'(ch));
    chk({nm, "_frac"},   32'(out_frac_o),    32'(23'(id)));
    chk({nm, "_coarse"}, 32'(out_coarse_o),  32'(28'(id + 1000)));
    chk({nm, "_utc"},    out_utc_o,          32'(id * 3 + 5));
  endtask

  task automatic tick();
    @(posedge clk_ref_i);
    #1;
  endtask

  task automatic strobe1(int c, int id);
    set_tag(c, id);
    tag_valid_p1_i = 4'(1 << c);
    tick();
    tag_valid_p1_i = '0;
  endtask

  task automatic strobe_n(logic [3:0] mask, int base);
    for (int c = 0; c < NC; c++) if (mask[c]) set_tag(c, base + c);
    tag_valid_p1_i = mask;
    tick();
    tag_valid_p1_i = '0;
  endtask

  task automatic expect_pop(string nm, int ch, int id);
    int n = 0;
    while (!out_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_valid"}, 32'(out_valid_o), 32'd1);
    chk_head(nm, ch, id);
    tick();
  endtask

  int seq3[3] = '{0, 2, 3};

  initial begin
    rst_n_i        = 1'b0;
    enable_i       = '1;
    tag_frac_i     = '0;
    tag_coarse_i   = '0;
    tag_utc_i      = '0;
    tag_valid_p1_i = '0;
    out_ready_i    = 1'b0;
    clear_i        = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid_o),  0);
    chk("rst_count", 32'(fifo_count_o), 0);
    chk("rst_drop",  32'(drop_count_o), 0);
    chk("rst_ovf",   32'(overflow_o),   0);
    chk("rst_frac",  32'(out_frac_o),   0);
    @(negedge clk_ref_i);
    rst_n_i = 1'b1;

    // en, vld, rdy, exp_valid, exp_chan, exp_row, exp_count
    add(4'hF, 4'b0100, 1, 0, 0,  0, 0);  // 0: single tag on ch2
    add(4'hF, 4'b0000, 1, 1, 2,  0, 1);  // 1: appears two edges after strobe
    add(4'hF, 4'b0000, 1, 0, 0,  0, 0);  // 2: popped
    add(4'hF, 4'b1000, 1, 0, 0,  0, 0);  // 3: ch3 brings pointer back to 0
    add(4'hF, 4'b0000, 1, 1, 3,  3, 1);
    add(4'hF, 4'b0000, 1, 0, 0,  0, 0);
    add(4'hF, 4'b1111, 1, 0, 0,  0, 0);  // 6: burst, ready high
    add(4'hF, 4'b0000, 1, 1, 0,  6, 1);
    add(4'hF, 4'b0000, 1, 1, 1,  6, 1);
    add(4'hF, 4'b0000, 1, 1, 2,  6, 1);
    add(4'hF, 4'b0000, 1, 1, 3,  6, 1);
    add(4'hF, 4'b0000, 1, 0, 0,  0, 0);
    add(4'hF, 4'b1111, 0, 0, 0,  0, 0);  // 12: burst, ready low
    add(4'hF, 4'b0000, 0, 1, 0, 12, 1);
    add(4'hF, 4'b0000, 0, 1, 0, 12, 2);
    add(4'hF, 4'b0000, 0, 1, 0, 12, 3);
    add(4'hF, 4'b0000, 0, 1, 0, 12, 4);
    add(4'hF, 4'b0000, 1, 1, 1, 12, 3);
    add(4'hF, 4'b0000, 1, 1, 2, 12, 2);
    add(4'hF, 4'b0000, 1, 1, 3, 12, 1);
    add(4'hF, 4'b0000, 1, 0, 0,  0, 0);
    add(4'h7, 4'b1000, 1, 0, 0,  0, 0);  // 21: ch3 disabled
    add(4'h7, 4'b1000, 1, 0, 0,  0, 0);
    add(4'h7, 4'b1000, 1, 0, 0,  0, 0);
    add(4'hF, 4'b1000, 1, 0, 0,  0, 0);  // 24: ch3 re-enabled
    add(4'hF, 4'b0000, 1, 1, 3, 24, 1);
    add(4'hF, 4'b0000, 1, 0, 0,  0, 0);

    foreach (tbl[r]) begin
      enable_i    = tbl[r].en;
      out_ready_i = tbl[r].rdy;
      for (int c = 0; c < NC; c++) if (tbl[r].vld[c]) set_tag(c, r * 16 + c);
      tag_valid_p1_i = tbl[r].vld;
      tick();
      tag_valid_p1_i = '0;
      chk($sformatf("vec%0d_valid", r), 32'(out_valid_o),  32'(tbl[r].ev));
      chk($sformatf("vec%0d_count", r), 32'(fifo_count_o), 32'(tbl[r].ecnt));
      chk($sformatf("vec%0d_drop",  r), 32'(drop_count_o), 0);
      chk($sformatf("vec%0d_ovf",   r), 32'(overflow_o),   0);
      if (tbl[r].ev) chk_head($sformatf("vec%0d", r), tbl[r].ech, tbl[r].erow * 16 + tbl[r].ech);
    end

    // Full FIFO: 16 queued plus one held tag on every channel.
    enable_i    = '1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) strobe1(i % 4, 2000 + i);
    tick();
    tick();
    chk("full_count", 32'(fifo_count_o), 16);
    chk("full_valid", 32'(out_valid_o),  1);
    chk("full_drop",  32'(drop_count_o), 0);
    chk_head("full_head", 0, 2000);
    strobe_n(4'hF, 3000);
    chk("full_drop4", 32'(drop_count_o), 4);
    chk("full_ovf",   32'(overflow_o),   32'hF);
    strobe1(2, 3010);
    chk("full_drop5", 32'(drop_count_o), 5);
    chk("full_count2", 32'(fifo_count_o), 16);
    chk_head("full_stable", 0, 2000);
    out_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) expect_pop($sformatf("drain%0d", k), k % 4, 2000 + k);
    tick();
    tick();
    chk("drain_count", 32'(fifo_count_o), 0);
    chk("drain_valid", 32'(out_valid_o),  0);
    chk("drain_drop",  32'(drop_count_o), 5);
    chk("drain_ovf",   32'(overflow_o),   32'hF);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_drop", 32'(drop_count_o), 0);
    chk("clr_ovf",  32'(overflow_o),   0);

    // Overflow on ch1 with the FIFO full, then clear against a drop.
    out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) strobe1(seq3[i % 3], 4000 + i);
    tick();
    chk("ovf_count", 32'(fifo_count_o), 16);
    strobe1(1, 4100);
    strobe1(1, 4101);
    strobe1(1, 4102);
    chk("ovf_drop", 32'(drop_count_o), 2);
    chk("ovf_flag", 32'(overflow_o),   32'b0010);
    clear_i = 1'b1;
    strobe1(1, 4103);
    clear_i = 1'b0;
    chk("clrpri_drop", 32'(drop_count_o), 0);
    chk("clrpri_ovf",  32'(overflow_o),   0);
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) expect_pop($sformatf("ovfdrain%0d", i), seq3[i % 3], 4000 + i);
    expect_pop("ovfheld", 1, 4100);
    tick();
    chk("ovfdrain_count", 32'(fifo_count_o), 0);

    // Reset mid-stream with queued entries and a recorded drop.
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) strobe1(i % 4, 5000 + i);
    tick();
    strobe_n(4'b1100, 5100);
    strobe_n(4'b1100, 5200);
    tick();
    tick();
    tick();
    chk("pre_rst_count", 32'(fifo_count_o), 11);
    chk("pre_rst_drop",  32'(drop_count_o), 1);
    chk("pre_rst_ovf",   32'(overflow_o),   32'b1000);
    @(posedge clk_ref_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o),  0);
    chk("arst_count", 32'(fifo_count_o), 0);
    chk("arst_ovf",   32'(overflow_o),   0);
    chk("arst_drop",  32'(drop_count_o), 0);
    chk("arst_chan",  32'(out_channel_o), 0);
    @(posedge clk_ref_i);
    @(negedge clk_ref_i);
    rst_n_i = 1'b1;
    strobe_n(4'b1100, 6000);
    chk("post_rst_valid", 32'(out_valid_o), 0);
    out_ready_i = 1'b1;
    expect_pop("post_rst0", 2, 6002);
    expect_pop("post_rst1", 3, 6003);
    tick();
    chk("post_rst_count", 32'(fifo_count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_tag_arbiter.md
Name: ts_tag_arbiter

Overview:
Collects timestamp tags from g_num_channels timestamper instances and serialises them into one channel-tagged output stream. Each channel gets a one-deep holding register. A round-robin arbiter moves pending tags into a shared first-word-fall-through FIFO, which the readout logic (DMA/host interface) drains through a valid/ready handshake. Tags that arrive while a channel's holding register is still occupied are dropped and counted.

Parameters:
g_num_channels, 4, number of timestamper channels (2..8)
g_fifo_depth, 16, output FIFO depth in entries; must be a power of 2 and at least 2

Ports:
clk_ref_i  in  1  reference clock; all logic is in this domain
rst_n_i  in  1  reset, asynchronous, active-low
enable_i  in  g_num_channels  per-channel acceptance enable
tag_frac_i  in  23*g_num_channels  fractional tag; channel c occupies bits [23c+22:23c]
tag_coarse_i  in  28*g_num_channels  coarse tag, packed the same way
tag_utc_i  in  32*g_num_channels  UTC seconds tag, packed the same way
tag_valid_p1_i  in  g_num_channels  single-cycle tag strobe per channel
out_frac_o  out  23  FIFO head fractional field
out_coarse_o  out  28  FIFO head coarse field
out_utc_o  out  32  FIFO head UTC field
out_channel_o  out  3  FIFO head source channel index
out_valid_o  out  1  FIFO not empty
out_ready_i  in  1  consumer accepts the head entry
fifo_count_o  out  $clog2(g_fifo_depth)+1  current FIFO occupancy
overflow_o  out  g_num_channels  sticky per-channel drop flags
drop_count_o  out  16  saturating count of all dropped tags
clear_i  in  1  pulse; clears overflow_o and drop_count_o

Behaviour:
- Reset (async assert, sync release). All outputs are 0, the FIFO is empty, all holding registers are empty, and the round-robin pointer is 0. Reset applied mid-operation discards all pending and queued tags immediately.
- Capture. At an edge where tag_valid_p1_i[c] and enable_i[c] are both 1:
  - If holding[c] is empty, or is being granted in that same cycle, the channel's {utc, coarse, frac} is loaded and pending[c] is set.
  - Otherwise the tag is dropped, overflow_o[c] is set to 1, and drop_count_o increments, saturating at 0xFFFF.
  - When enable_i[c] is 0, strobes are ignored and not counted. Tags already pending still drain.
- Arbitration. Evaluated every cycle, combinationally from pending, the pointer, and fifo_count_o:
  - A grant is allowed only when fifo_count_o < g_fifo_depth. There is no full-bypass, even if a pop happens in the same cycle.
  - The grant goes to the first pending channel found searching upward from the pointer, with wrap-around.
  - On a grant to channel g: the entry {g, utc, coarse, frac} is written at the next edge, pending[g] is cleared unless it is reloaded that same edge, and the pointer becomes (g+1) mod g_num_channels.
  - With no grant, the pointer holds.
  - At most one grant per cycle.
- Latency.
  - A strobe sampled at edge k sets pending at k.
  - With the FIFO empty and no contention, the tag is granted in the cycle after k, written at edge k+1, and out_valid_o rises after edge k+1.
  - Minimum latency is therefore 2 edges from strobe to out_valid_o.
- Output handshake.
  - out_valid_o = (count != 0), and the head fields are valid whenever out_valid_o is 1.
  - A pop occurs at an edge where out_valid_o and out_ready_i are both 1.
  - Head fields are stable while out_valid_o=1 and out_ready_i=0.
  - out_ready_i is ignored while out_valid_o=0.
  - A push and a pop in the same cycle leave the count unchanged.
  - An empty FIFO with a push presents the entry the next cycle (no combinational path from input to output).
- Counters.
  - fifo_count_o ranges over 0..g_fifo_depth; read and write pointers wrap modulo g_fifo_depth.
  - clear_i has priority over a same-cycle drop: after that edge the flag is 0 and the counter is 0.
  - Flags and counter are unaffected by FIFO activity.
- Sustained throughput is one tag per cycle in aggregate. A single channel strobing every cycle with out_ready_i=1 and no other traffic loses nothing.

Test Plan:
1. Single tag: ch2 strobes {utc=5, coarse=1000, frac=77} at edge k with out_ready_i=1 -> out_valid_o=1 after edge k+1 with channel=2 and exact fields; fifo_count_o returns to 0; drop_count_o=0.
2. Round-robin: all 4 channels strobe at the same edge with the pointer at 0 -> output channel order 0,1,2,3; a second simultaneous burst with the pointer at 0 -> order again 0,1,2,3, with no drops.
3. Full FIFO (depth 16): out_ready_i=0 and 20 strobes spread over channels -> fifo_count_o=16, out_valid_o=1, exactly 4 channels hold pending tags; further strobes on those channels are dropped, setting overflow_o bits and incrementing drop_count_o by 1 each; releasing ready drains 16 entries plus the held tags in order with no corruption.
4. Overflow and clear: ch1 strobes 3 consecutive cycles with the FIFO full -> pending holds the first tag, drop_count_o=2, overflow_o=4'b0010; clear_i coinciding with a further drop -> both read 0 afterwards.
5. Enable gating: enable_i[3]=0 with 10 strobes on ch3 -> no entries and no drops; set enable_i[3]=1 and strobe once -> exactly one entry with channel=3.
6. Reset mid-stream: assert rst_n_i low asynchronously with 8 entries queued -> out_valid_o, fifo_count_o, overflow_o and drop_count_o all 0 before the next clock edge; after release, the first tag accepted is granted starting from pointer 0.
